instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the CPU datapath/decode.
//  - Owns the fetch PC and issues word reads to a synchronous instruction memory (fixed 1-cycle read latency).
//  - Buffers returned words with their PC in a small FIFO.
//  - Presents them to decode over a valid/ready handshake.
//  - Branch/jump redirects flush the FIFO and restart fetch at a new PC.

---
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues word reads to a 1-cycle
// synchronous instruction memory, buffers returned words with their PC in a
// small FIFO and hands them to decode over valid/ready.
// Build option: define IFU_MISALIGN_TRAP_EN to trap misaligned redirects
// (sticky fetch_fault, park in HALT until an aligned redirect arrives).
// Without it the low two redirect bits are simply dropped.
//
// state | meaning
// IDLE  | first cycle after reset release, no request issued
// RUN   | normal fetching
// HALT  | parked after a misaligned redirect (trap build only)
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [XLEN-1:0]  fetch_pc_q;
    logic [XLEN-1:0]  req_pc_q;
    logic             inflight_q;
    logic [XLEN-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] committed;
    logic             issue;
    logic             push;
    logic             pop;
    logic             misalign;

    assign misalign   = (redirect_pc[1:0] != 2'b00);
    assign inst_valid = (occ_q != '0);
    assign pop        = inst_valid && inst_ready;
    // No request issues in a redirect cycle, so the only response that can be
    // stale is the one returning in that same cycle: killing it here is enough.
    assign push       = inflight_q && !redirect_valid;
    // Slots already spoken for once this cycle's pop is taken into account.
    assign committed  = occ_q + CNT_W'(inflight_q) - CNT_W'(pop);
    assign imem_req   = issue;
    assign imem_addr  = fetch_pc_q;
    assign inst_data  = fifo_data_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and request decision; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  issue   = (committed < CNT_W'(FIFO_DEPTH));
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
        if (redirect_valid) begin
            issue = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            state_d = misalign ? ST_HALT : ST_RUN;
`else
            state_d = ST_RUN;
`endif
        end
    end

    // Fetch PC, in-flight tracking and FIFO pointers/occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= fetch_pc_q;
            end
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                occ_q      <= '0;
            end else begin
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + XLEN'(4);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage; contents are meaningless unless counted in occ_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    logic fault_q;

    // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= misalign;
        end
    end

    assign fetch_fault = fault_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign fetch_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing checks plus a randomized phase.
// A monitor checks every accepted instruction against a stream model (next
// expected PC, data = address + 1); redirect targets are queued by stimulus.
// A second instance covers a reset PC that wraps through zero.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC1 = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0 = 1'b1, req0, redir0 = 1'b0, valid0, ready0 = 1'b0, fault0;
    logic [31:0] addr0, rdata0 = '0, redir_pc0 = '0, data0, pc0;
    logic        reset1 = 1'b1, req1, redir1 = 1'b0, valid1, ready1 = 1'b1, fault1;
    logic [31:0] addr1, rdata1 = '0, redir_pc1 = '0, data1, pc1;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut0 (
        .clk(clk), .reset(reset0), .imem_req(req0), .imem_addr(addr0),
        .imem_rdata(rdata0), .redirect_valid(redir0), .redirect_pc(redir_pc0),
        .inst_valid(valid0), .inst_ready(ready0), .inst_data(data0),
        .inst_pc(pc0), .fetch_fault(fault0)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC1), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .reset(reset1), .imem_req(req1), .imem_addr(addr1),
        .imem_rdata(rdata1), .redirect_valid(redir1), .redirect_pc(redir_pc1),
        .inst_valid(valid1), .inst_ready(ready1), .inst_data(data1),
        .inst_pc(pc1), .fetch_fault(fault1)
    );

    // Instruction memory: word at byte address a holds a + 1.
    always @(posedge clk) if (req0) rdata0 <= addr0 + 32'd1;
    always @(posedge clk) if (req1) rdata1 <= addr1 + 32'd1;

    int          total = 0;
    int          bad   = 0;
    bit          started = 1'b0;
    logic [31:0] redir_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves the caller in cycle 0 (first cycle with reset low).
    task automatic do_reset0();
        reset0 = 1'b1;
        ready0 = 1'b0;
        redir0 = 1'b0;
        repeat (3) tick();
        reset0 = 1'b0;
    endtask

    task automatic drive_redirect(input logic [31:0] tgt);
        redir0    = 1'b1;
        redir_pc0 = tgt;
        redir_q.push_back(tgt);
    endtask

    // Monitor / scoreboard for dut0.
    initial begin
        logic [31:0] model_pc, hold_pc, hold_data, tgt;
        bit          halted, hold_prev, redir_prev, rst_prev;
        int          stall;
        model_pc = '0; hold_pc = '0; hold_data = '0; tgt = '0;
        halted = 0; hold_prev = 0; redir_prev = 0; rst_prev = 0; stall = 0;
        forever begin
            smp();
            if (!started) continue;
            if (reset0) begin
                model_pc = 32'h0; halted = 0; stall = 0;
                hold_prev = 0; redir_prev = 0; rst_prev = 1;
                continue;
            end
            if (rst_prev || redir_prev) chk("valid_after_flush", 32'(valid0), 32'd0);
            if (hold_prev) begin
                chk("hold_valid", 32'(valid0), 32'd1);
                chk("hold_pc", pc0, hold_pc);
                chk("hold_data", data0, hold_data);
            end
            if (req0) chk("addr_aligned", 32'(addr0[1:0]), 32'd0);
            if (halted) chk("halt_no_req", 32'(req0), 32'd0);
            if (valid0 && ready0) begin
                chk("accept_in_halt", 32'(halted), 32'd0);
                chk("accept_pc", pc0, model_pc);
                chk("accept_data", data0, model_pc + 32'd1);
                model_pc = model_pc + 32'd4;
                stall = 0;
            end else if (ready0 && !halted) begin
                stall++;
            end
            chk("stall_bound", 32'(stall <= 5), 32'd1);
            if (redir0) begin
                chk("redirect_no_req", 32'(req0), 32'd0);
                chk("redirect_queue", 32'(redir_q.size()), 32'd1);
                if (redir_q.size() > 0) begin
                    tgt = redir_q.pop_front();
`ifdef IFU_MISALIGN_TRAP_EN
                    halted = (tgt[1:0] != 2'b00);
`else
                    halted = 0;
`endif
                    model_pc = {tgt[31:2], 2'b00};
                end
                stall = 0;
            end
`ifndef IFU_MISALIGN_TRAP_EN
            chk("fault_tied_low", 32'(fault0), 32'd0);
`endif
            hold_prev  = valid0 && !ready0 && !redir0;
            hold_pc    = pc0;
            hold_data  = data0;
            redir_prev = redir0;
            rst_prev   = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        started = 1'b1;

        // Reset release and steady streaming.
        do_reset0();
        ready0 = 1'b1;
        smp();
        chk("t1_idle_req", 32'(req0), 32'd0);
        chk("t1_idle_valid", 32'(valid0), 32'd0);
        chk("t1_idle_addr", addr0, 32'h0);
        chk("t1_idle_fault", 32'(fault0), 32'd0);
        tick(); smp();
        chk("t1_first_req", 32'(req0), 32'd1);
        chk("t1_first_addr", addr0, 32'h0);
        tick(); smp();
        chk("t1_c2_valid", 32'(valid0), 32'd0);
        chk("t1_c2_addr", addr0, 32'h4);
        tick(); smp();
        chk("t1_c3_valid", 32'(valid0), 32'd1);
        chk("t1_c3_pc", pc0, 32'h0);
        chk("t1_c3_data", data0, 32'h1);
        for (int c = 4; c <= 9; c++) begin
            tick(); smp();
            chk("t1_stream_valid", 32'(valid0), 32'd1);
            chk("t1_stream_pc", pc0, 32'((c - 3) * 4));
        end

        // Decode stall for five cycles from cycle 3.
        do_reset0();
        ready0 = 1'b1;
        tick(); tick();
        for (int c = 3; c <= 7; c++) begin
            tick();
            ready0 = 1'b0;
            smp();
            chk("t2_stall_req", 32'(req0), 32'd0);
            chk("t2_stall_valid", 32'(valid0), 32'd1);
            chk("t2_stall_pc", pc0, 32'h0);
        end
        tick();
        ready0 = 1'b1;
        smp();
        chk("t2_resume_pc", pc0, 32'h0);
        chk("t2_resume_req", 32'(req0), 32'd1);
        chk("t2_resume_addr", addr0, 32'h8);
        repeat (4) tick();

        // Redirect with a full FIFO.
        do_reset0();
        for (int c = 1; c <= 5; c++) tick();
        tick();
        drive_redirect(32'h100);
        smp();
        chk("t3_full_valid", 32'(valid0), 32'd1);
        chk("t3_full_pc", pc0, 32'h0);
        tick();
        redir0 = 1'b0;
        ready0 = 1'b1;
        smp();
        chk("t3_after_valid", 32'(valid0), 32'd0);
        chk("t3_after_req", 32'(req0), 32'd1);
        chk("t3_after_addr", addr0, 32'h100);
        tick(); smp();
        tick(); smp();
        chk("t3_target_valid", 32'(valid0), 32'd1);
        chk("t3_target_pc", pc0, 32'h100);

        // Redirect coinciding with the pop of pc 0x8.
        do_reset0();
        ready0 = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        tick();
        drive_redirect(32'h200);
        smp();
        chk("t4_pop_valid", 32'(valid0), 32'd1);
        chk("t4_pop_pc", pc0, 32'h8);
        tick();
        redir0 = 1'b0;
        smp();
        chk("t4_after_valid", 32'(valid0), 32'd0);
        chk("t4_after_addr", addr0, 32'h200);
        tick(); smp();
        tick(); smp();
        chk("t4_target_pc", pc0, 32'h200);

        // Misaligned redirect.
        tick();
        drive_redirect(32'h102);
        smp();
        tick();
        redir0 = 1'b0;
        smp();
`ifdef IFU_MISALIGN_TRAP_EN
        chk("t5_fault_set", 32'(fault0), 32'd1);
        chk("t5_halt_req", 32'(req0), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick(); smp();
            chk("t5_halt_req", 32'(req0), 32'd0);
            chk("t5_halt_fault", 32'(fault0), 32'd1);
        end
        tick();
        drive_redirect(32'h200);
        smp();
        tick();
        redir0 = 1'b0;
        smp();
        chk("t5_fault_clear", 32'(fault0), 32'd0);
        chk("t5_resume_req", 32'(req0), 32'd1);
        chk("t5_resume_addr", addr0, 32'h200);
`else
        chk("t5_no_fault", 32'(fault0), 32'd0);
        chk("t5_resume_req", 32'(req0), 32'd1);
        chk("t5_resume_addr", addr0, 32'h100);
        tick(); smp();
        tick(); smp();
        chk("t5_resume_pc", pc0, 32'h100);
`endif
        repeat (3) tick();

        // Randomized traffic, redirects and occasional resets.
        do_reset0();
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset0 = ($urandom_range(0, 299) == 0);
            ready0 = ($urandom_range(0, 3) != 0);
            if (!reset0 && $urandom_range(0, 15) == 0) begin
                t = $urandom;
                if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
`ifdef IFU_MISALIGN_TRAP_EN
                if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
`endif
                drive_redirect(t);
            end else begin
                redir0 = 1'b0;
            end
        end
        tick();
        reset0 = 1'b0;
        redir0 = 1'b0;
        repeat (3) tick();

        // Wrapping reset PC and reset mid-stream on the second instance.
        tick();
        reset1 = 1'b0;
        smp();
        chk("t6_idle_req", 32'(req1), 32'd0);
        chk("t6_idle_valid", 32'(valid1), 32'd0);
        chk("t6_idle_addr", addr1, RST_PC1);
        tick(); smp();
        chk("t6_first_addr", addr1, RST_PC1);
        tick(); smp();
        tick(); smp();
        chk("t6_pc0", pc1, 32'hFFFF_FFF8);
        chk("t6_data0", data1, 32'hFFFF_FFF9);
        tick(); smp();
        chk("t6_pc1", pc1, 32'hFFFF_FFFC);
        chk("t6_data1", data1, 32'hFFFF_FFFD);
        tick(); smp();
        chk("t6_pc2_valid", 32'(valid1), 32'd1);
        chk("t6_pc2", pc1, 32'h0);
        chk("t6_data2", data1, 32'h1);
        tick();
        reset1 = 1'b1;
        smp();
        tick();
        reset1 = 1'b0;
        smp();
        chk("t6_rst_valid", 32'(valid1), 32'd0);
        chk("t6_rst_req", 32'(req1), 32'd0);
        chk("t6_rst_addr", addr1, RST_PC1);
        tick(); smp();
        chk("t6_refetch_req", 32'(req1), 32'd1);
        chk("t6_refetch_addr", addr1, RST_PC1);
        tick(); smp();
        chk("t6_stale_valid", 32'(valid1), 32'd0);
        tick(); smp();
        chk("t6_refetch_valid", 32'(valid1), 32'd1);
        chk("t6_refetch_pc", pc1, RST_PC1);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
